// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Watches a time-multiplexed seven-segment bus, qualifies each digit's
// pattern as stable, decodes it back to BCD and presents each complete,
// in-order scan of all digits as one parallel BCD word (valid/ready).
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   seg        in   [1:7] segment lines abcdefg (seg[1]=a), active-high
//   dig_sel    in   one-hot digit strobe, bit i = digit i
//   bcd_out    out  decoded frame, digit i at [4i+3:4i]
//   out_valid  out  frame available
//   out_ready  in   consumer accepts frame
//   overrun    out  sticky: a completed frame was dropped
//   err_digits out  per-digit invalid-pattern flag (SEG7_DEC_ERR_EN only)
//
// Optional feature macro: SEG7_DEC_ERR_EN (adds err_digits).
module seg7_scan_decoder #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:7]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    out_valid,
    input  logic                    out_ready,
`ifdef SEG7_DEC_ERR_EN
    output logic [NUM_DIGITS-1:0]   err_digits,
`endif
    output logic                    overrun
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BUS_W = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {
        WAIT0   = 1'b0,
        COLLECT = 1'b1
    } state_e;

    // Segment pattern back to BCD; unknown patterns map to 4'hF.
    function automatic logic [3:0] seg_decode(input logic [1:7] s);
        logic [3:0] d;
        case (s)
            7'b1111110: d = 4'd0;
            7'b0110000: d = 4'd1;
            7'b1101101: d = 4'd2;
            7'b1111001: d = 4'd3;
            7'b0110011: d = 4'd4;
            7'b1011011: d = 4'd5;
            7'b1011111: d = 4'd6;
            7'b1110000: d = 4'd7;
            7'b1111111: d = 4'd8;
            7'b1111011: d = 4'd9;
            default:    d = 4'hF;
        endcase
        return d;
    endfunction

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        exp_q, exp_d;
    logic [BUS_W-1:0]        shadow_q, shadow_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   sel_q;
    logic [1:7]              seg_q;
    logic [BUS_W-1:0]        bcd_q, bcd_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
`ifdef SEG7_DEC_ERR_EN
    logic [NUM_DIGITS-1:0]   err_q, err_d;
`endif

    logic                    onehot_c;
    logic                    same_c;
    logic                    accept_c;
    logic                    frame_done_c;
    logic [IDX_W-1:0]        idx_c;
    logic [3:0]              dec_c;

    assign onehot_c = (dig_sel != '0) &&
                      ((dig_sel & (dig_sel - NUM_DIGITS'(1))) == '0);
    assign same_c   = (dig_sel == sel_q) && (seg == seg_q) && (cnt_q != '0);
    assign dec_c    = seg_decode(seg);

    // One-hot strobe to digit index.
    always_comb begin
        idx_c = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (dig_sel[i]) idx_c = IDX_W'(i);
        end
    end

    // Stability counter; saturates so a held digit is accepted only once.
    always_comb begin
        cnt_d    = '0;
        accept_c = 1'b0;
        if (onehot_c) begin
            if (same_c) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            else        cnt_d = CNT_W'(1);
            accept_c = (cnt_d == CNT_MAX) && !(same_c && (cnt_q == CNT_MAX));
        end
    end

    // Frame FSM and output handshake.
    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        shadow_d     = shadow_q;
        bcd_d        = bcd_q;
        valid_d      = valid_q;
        overrun_d    = overrun_q;
        frame_done_c = 1'b0;
`ifdef SEG7_DEC_ERR_EN
        err_d        = err_q;
`endif
        if (accept_c) begin
            unique case (state_q)
                WAIT0: begin
                    if (idx_c == '0) begin
                        shadow_d[3:0] = dec_c;
                        if (NUM_DIGITS == 1) begin
                            frame_done_c = 1'b1;
                        end else begin
                            exp_d   = IDX_W'(1);
                            state_d = COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (idx_c == exp_q) begin
                        shadow_d[4*int'(idx_c) +: 4] = dec_c;
                        if (exp_q == IDX_LAST) begin
                            frame_done_c = 1'b1;
                            exp_d        = '0;
                            state_d      = WAIT0;
                        end else begin
                            exp_d = exp_q + IDX_W'(1);
                        end
                    end else if (idx_c == '0) begin
                        // Out-of-order digit 0 starts a fresh frame.
                        shadow_d[3:0] = dec_c;
                        exp_d         = IDX_W'(1);
                    end else begin
                        exp_d   = '0;
                        state_d = WAIT0;
                    end
                end
                default: begin
                    exp_d   = '0;
                    state_d = WAIT0;
                end
            endcase
        end

        if (frame_done_c) begin
            if (!valid_q || out_ready) begin
                bcd_d   = shadow_d;
                valid_d = 1'b1;
`ifdef SEG7_DEC_ERR_EN
                for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                    err_d[i] = (shadow_d[4*i +: 4] == 4'hF);
                end
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= WAIT0;
            exp_q     <= '0;
            shadow_q  <= '0;
            cnt_q     <= '0;
            sel_q     <= '0;
            seg_q     <= '0;
            bcd_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef SEG7_DEC_ERR_EN
            err_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            shadow_q  <= shadow_d;
            cnt_q     <= cnt_d;
            sel_q     <= dig_sel;
            seg_q     <= seg;
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
`ifdef SEG7_DEC_ERR_EN
            err_q     <= err_d;
`endif
        end
    end

    assign bcd_out   = bcd_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;
`ifdef SEG7_DEC_ERR_EN
    assign err_digits = err_q;
`endif

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side counterpart of the BCD-to-seven-segment display path: watches a time-multiplexed seven-segment bus (shared segment lines plus a one-hot digit strobe), qualifies each digit's pattern as stable, and decodes it back to BCD. A complete, in-order scan of all digits is presented as one parallel BCD word with a valid/ready handshake. Used by display self-check benches and readback logic.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (≥1)
- STABLE_CYCLES, 3, consecutive identical cycles required to accept a digit (≥1)
- clock  in  1  rising-edge clock; all inputs synchronous to it
- reset  in  1  asynchronous, active-high reset
- seg  in  [1:7]  segment lines, order abcdefg (seg[1]=a … seg[7]=g), active-high
- dig_sel  in  NUM_DIGITS  one-hot digit strobe; bit i = digit i
- bcd_out  out  4*NUM_DIGITS  decoded frame; digit i at [4i+3:4i]
- out_valid  out  1  frame available
- out_ready  in  1  consumer accepts frame
- overrun  out  1  sticky: a completed frame was dropped
- err_digits  out  NUM_DIGITS  per-digit invalid-pattern flag (only with SEG7_DEC_ERR_EN)

## Operation
- Decode (abcdefg→BCD): 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9; any other pattern → 4'hF.
- Stability: counter tracks consecutive cycles with the same one-hot dig_sel and same seg. Any change in either restarts count at 1. dig_sel zero or multi-hot: counter cleared, nothing latched.
- Digit accepted in the cycle count reaches STABLE_CYCLES; at most once per strobe period (re-armed when dig_sel or seg changes).
- Frame FSM, expected index exp:
  - WAIT0 (reset): only an accepted digit 0 is latched into shadow; exp←1, go COLLECT (NUM_DIGITS=1: frame completes immediately).
  - COLLECT: accepted digit == exp → latch, exp+1. Accepted digit 0 → restart frame with it (exp←1). Any other index → discard shadow, go WAIT0.
  - Latching digit NUM_DIGITS-1 completes the frame; return to WAIT0.
- Frame completion: if out_valid=0, or out_valid=1 and out_ready=1 that cycle → bcd_out←frame, out_valid←1. If out_valid=1 and out_ready=0 → frame dropped, bcd_out unchanged, overrun←1.
- Handshake: out_valid&&out_ready with no simultaneous completion → out_valid←0. bcd_out held stable while out_valid=1 and not accepted.
- overrun clears only on reset.

## Timing
- Reset (async, immediate): bcd_out=0, out_valid=0, overrun=0, err_digits=0, FSM=WAIT0, exp=0, counter=0.
- Digit with strobe first seen in cycle t is accepted at edge ending cycle t+STABLE_CYCLES-1.
- out_valid/bcd_out update at the edge ending the last digit's acceptance cycle; visible the following cycle. No combinational input→output paths.
- Reset asserted mid-frame: partial shadow discarded; first frame after release must start at digit 0.

## Configuration
- SEG7_DEC_ERR_EN defined: err_digits port present; bit i = 1 when digit i of the presented frame decoded to 4'hF; updated with bcd_out, reset 0.
- Undefined: err_digits port and its registers absent; invalid patterns still decode to 4'hF silently.

## Test plan
- NUM_DIGITS=4, STABLE_CYCLES=3; scan digits 0..3 with patterns for 1,2,3,4, each held 4 cycles, out_ready=1 → out_valid pulses 1 cycle, bcd_out=16'h4321.
- Digit 1 held only 2 cycles then digit 2 → digit 1 never accepted; digit 2 aborts frame to WAIT0; no out_valid until a full in-order scan.
- Two full scans (5678 then 9012) with out_ready=0 → bcd_out stays 16'h8765, overrun=1; assert out_ready → out_valid drops next cycle.
- Frame completes in same cycle out_ready=1 on a held frame → new value loaded, out_valid stays 1, overrun stays 0.
- Digit 2 pattern 0000001 (ERR_EN) → bcd_out[11:8]=4'hF, err_digits=4'b0100; dig_sel=4'b0011 for 5 cycles → nothing latched.
- Reset pulsed after digits 0,1 accepted → all outputs 0 immediately; subsequent scan starting at digit 2 produces no frame.
